keygen_mul_pipe: RTL

//  Parametrised pipelined integer multiplier for the Falcon keygen datapath.

---
 rtl/keygen_mul_pipe_if.sv | 28 ++
 rtl/keygen_mul_pipe.sv | 125 ++++++++++++
 2 files changed

// File: rtl/keygen_mul_pipe_if.sv
// Operand/result valid-ready bundle for keygen_mul_pipe.
// acc_clr exists only when KEYGEN_MUL_ACC_EN is defined.
interface keygen_mul_pipe_if #(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 15,
    parameter int DOUT_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIN0_WIDTH-1:0] din0;
    logic [DIN1_WIDTH-1:0] din1;
    logic                  out_valid;
    logic                  out_ready;
    logic [DOUT_WIDTH-1:0] dout;
`ifdef KEYGEN_MUL_ACC_EN
    logic                  acc_clr;

    modport master (output in_valid, din0, din1, out_ready, acc_clr,
                    input  in_ready, out_valid, dout);
    modport slave  (input  in_valid, din0, din1, out_ready, acc_clr,
                    output in_ready, out_valid, dout);
`else
    modport master (output in_valid, din0, din1, out_ready,
                    input  in_ready, out_valid, dout);
    modport slave  (input  in_valid, din0, din1, out_ready,
                    output in_ready, out_valid, dout);
`endif
endinterface

// File: rtl/keygen_mul_pipe.sv
// Stallable pipelined multiplier with product bit-slice output and valid/ready flow control.
// Optional accumulate-in-final-stage mode is enabled by defining KEYGEN_MUL_ACC_EN.
module keygen_mul_pipe #(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 15,
    parameter int DOUT_WIDTH = 16,
    parameter int NUM_STAGE  = 4,
    parameter int SIGNED0    = 0,
    parameter int SIGNED1    = 0,
    parameter int OUT_LSB    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    keygen_mul_pipe_if.slave  bus
);
    localparam int P_W   = DIN0_WIDTH + DIN1_WIDTH;
    localparam int EXT_W = P_W + OUT_LSB + DOUT_WIDTH;
    localparam bit SGN   = (SIGNED0 != 0) || (SIGNED1 != 0);

    generate
        if (NUM_STAGE < 2 || NUM_STAGE > 8) begin : g_bad_stage
            $error("keygen_mul_pipe: NUM_STAGE must be in 2..8");
        end
        if (OUT_LSB >= P_W) begin : g_bad_lsb
            $error("keygen_mul_pipe: OUT_LSB must be below DIN0_WIDTH+DIN1_WIDTH");
        end
    endgenerate

    // Whole pipeline moves together; a held output blocks every stage.
    logic                 adv, accept;
    logic [NUM_STAGE:1]   vld_pipe;

    assign adv           = ce & (~vld_pipe[NUM_STAGE] | bus.out_ready);
    assign accept        = bus.in_valid & adv;
    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_pipe[NUM_STAGE];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            vld_pipe <= '0;
        else if (adv)
            vld_pipe <= {vld_pipe[NUM_STAGE-1:1], accept};
    end

    // Operands carry one extra bit so signed and unsigned share one signed multiply.
    logic signed [DIN0_WIDTH:0] a_r;
    logic signed [DIN1_WIDTH:0] b_r;
    logic [P_W-1:0]             prod, p_tail;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r <= '0;
            b_r <= '0;
        end else if (accept) begin
            a_r <= {(SIGNED0 != 0) & bus.din0[DIN0_WIDTH-1], bus.din0};
            b_r <= {(SIGNED1 != 0) & bus.din1[DIN1_WIDTH-1], bus.din1};
        end
    end

    assign prod = P_W'(a_r) * P_W'(b_r);

    generate
        if (NUM_STAGE == 2) begin : g_short
            assign p_tail = prod;
        end else begin : g_retime
            logic [P_W-1:0] p_sr [NUM_STAGE-2];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < NUM_STAGE-2; k++) p_sr[k] <= '0;
                end else if (adv) begin
                    p_sr[0] <= prod;
                    for (int k = 1; k < NUM_STAGE-2; k++) p_sr[k] <= p_sr[k-1];
                end
            end
            assign p_tail = p_sr[NUM_STAGE-3];
        end
    endgenerate

    function automatic logic [DOUT_WIDTH-1:0] slice(input logic [P_W-1:0] v);
        logic [EXT_W-1:0] ext;
        ext = {{(EXT_W-P_W){SGN & v[P_W-1]}}, v};
        return ext[OUT_LSB +: DOUT_WIDTH];
    endfunction

    logic [DOUT_WIDTH-1:0] dout_r;
    logic                  last_vld;
    assign last_vld = adv & vld_pipe[NUM_STAGE-1];

`ifdef KEYGEN_MUL_ACC_EN
    logic [NUM_STAGE-1:1] clr_pipe;
    logic [P_W-1:0]       acc, acc_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_pipe <= '0;
        end else if (adv) begin
            clr_pipe[1] <= bus.acc_clr;
            for (int k = 2; k < NUM_STAGE; k++) clr_pipe[k] <= clr_pipe[k-1];
        end
    end

    // Wraps modulo 2^P_W; only valid beats touch the accumulator.
    assign acc_nxt = clr_pipe[NUM_STAGE-1] ? p_tail : acc + p_tail;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            dout_r <= '0;
        end else if (last_vld) begin
            acc    <= acc_nxt;
            dout_r <= slice(acc_nxt);
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            dout_r <= '0;
        else if (last_vld)
            dout_r <= slice(p_tail);
    end
`endif

    assign bus.dout = dout_r;
endmodule
